mem_access_unit: RTL and testbench

Initiator side of the data-memory port. Accepts load/store requests from the vector pipeline over a valid/ready handshake and drives `DataMemory` (`we`, `vf`, `addr`, `wd`) as its only master. Read data (`rd`) is returned to the pipeline as a stream of response beats. Bursts of consecutive scalars or vectors are supported, which covers the alpha-composition pixel streams.

---
 rtl/mau_pkg.sv | 9 +
 rtl/mau_addr_gen.sv | 37 +++
 rtl/mem_access_unit.sv | 95 +++++++++
 tb/tb_mem_access_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared state encoding and lane/step constants for the memory access unit.
package mau_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} mau_state_t;
    localparam int LANE_W   = 32;
    localparam int LANES    = 4;
    localparam int VEC_W    = LANE_W * LANES;
    localparam int VEC_STEP = 4;
    localparam int SCL_STEP = 1;
endpackage

// File: rtl/mau_addr_gen.sv
// mau_addr_gen: beat address/count registers with step, silent wrap, bounds check and last-beat flag.
module mau_addr_gen
    import mau_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic              vec,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        start_count,
    output logic [ADDR_W-1:0] addr,
    output logic              oob,
    output logic              last
);
    logic [7:0]      count;
    logic [ADDR_W:0] span;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= start_addr;
            count <= start_count;
        end else if (advance) begin
            addr  <= addr + (vec ? ADDR_W'(VEC_STEP) : ADDR_W'(SCL_STEP));
            count <= count - 8'd1;
        end
    end
    // One extra bit so a vector beat straddling the top of the address space is still out of range.
    assign span = {1'b0, addr} + (vec ? (ADDR_W+1)'(3) : '0);
    assign oob  = span >= (ADDR_W+1)'(MEM_WORDS);
    assign last = count == 8'd1;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator driving DataMemory, with bursts and per-beat bounds check.
// Define MAU_SCALAR_EN to enable scalar (lane 0) accesses; otherwise every access is a vector.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_vec,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_count,
    input  logic [VEC_W-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [VEC_W-1:0]  rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              mem_we,
    output logic              mem_vf,
    output logic [VEC_W-1:0]  mem_addr,
    output logic [VEC_W-1:0]  mem_wd,
    input  logic [VEC_W-1:0]  mem_rd
);
    mau_state_t        state, next;
    logic              vec_q, err_q, accept, advance, vec_in, oob, last, live;
    logic [VEC_W-1:0]  wdata_q, rdata_q, rd_lane;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        start_count;
`ifdef MAU_SCALAR_EN
    assign vec_in  = req_vec;
    assign rd_lane = vec_q ? mem_rd : VEC_W'(mem_rd[LANE_W-1:0]);
`else
    logic unused_vec;
    assign unused_vec = req_vec;
    assign vec_in     = 1'b1;
    assign rd_lane    = mem_rd;
`endif
    assign accept      = req_valid & req_ready;
    assign advance     = (state == RESP) & rsp_ready & ~last;
    assign start_count = (req_write || req_count == 8'd0) ? 8'd1 : req_count;
    assign live        = ((state == READ) || (state == WRITE)) & ~oob;
    mau_addr_gen #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_addr_gen (
        .clk(clk), .rst(rst), .load(accept), .advance(advance), .vec(vec_q),
        .start_addr(req_addr), .start_count(start_count),
        .addr(addr), .oob(oob), .last(last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    always_comb begin
        next      = state;
        req_ready = (state == IDLE) & ~rst;
        rsp_valid = state == RESP;
        rsp_last  = (state == RESP) & last;
        rsp_err   = (state == RESP) & err_q;
        rsp_rdata = (state == RESP) ? rdata_q : '0;
        mem_we    = (state == WRITE) & ~oob;
        mem_vf    = ((state == READ) || (state == WRITE)) & vec_q;
        mem_addr  = live ? VEC_W'(addr) : '0;
        mem_wd    = (state == WRITE) ? wdata_q : '0;
        unique case (state)
            IDLE:        if (accept) next = req_write ? WRITE : READ;
            WRITE, READ: next = RESP;
            RESP:        if (rsp_ready) next = last ? IDLE : READ;
            default:     next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                vec_q   <= vec_in;
                wdata_q <= req_wdata;
            end
            if (state == READ) begin
                err_q   <= oob;
                rdata_q <= oob ? '0 : rd_lane;
            end
            if (state == WRITE) begin
                err_q   <= oob;
                rdata_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a behavioural DataMemory.
module tb_mem_access_unit;
    localparam int MW = 16384;
`ifdef MAU_SCALAR_EN
    localparam logic SCL_VF = 1'b0;
`else
    localparam logic SCL_VF = 1'b1;
`endif
    logic         clk = 1'b0, rst = 1'b1;
    logic         req_valid = 1'b0, req_ready, req_write = 1'b0, req_vec = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [7:0]   req_count = '0;
    logic [127:0] req_wdata = '0;
    logic         rsp_valid, rsp_ready = 1'b1, rsp_last, rsp_err;
    logic [127:0] rsp_rdata;
    logic         mem_we, mem_vf;
    logic [127:0] mem_addr, mem_wd, mem_rd;
    logic [31:0]  mem [0:MW-1];
    int           errors = 0, checks = 0, we_cycles = 0, wb;
    localparam logic [127:0] VDATA = 128'h00000004_00000003_00000002_00000001;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_vec(req_vec), .req_addr(req_addr),
        .req_count(req_count), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .mem_we(mem_we), .mem_vf(mem_vf), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always @(posedge clk) begin
        if (mem_we) begin
            we_cycles++;
            for (int i = 0; i < 4; i++) begin
                int a;
                a = int'(mem_addr[31:0]) + i;
                if ((mem_vf || i == 0) && a >= 0 && a < MW) mem[a] <= mem_wd[32*i +: 32];
            end
        end
    end

    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < 4; i++) begin
            int a;
            a = int'(mem_addr[31:0]) + i;
            if ((mem_vf || i == 0) && a >= 0 && a < MW) mem_rd[32*i +: 32] = mem[a];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int a);
        return {32'h100 + 32'(a + 3), 32'h100 + 32'(a + 2), 32'h100 + 32'(a + 1), 32'h100 + 32'(a)};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the READ/WRITE cycle.
    task automatic send(input logic w, input logic v, input logic [31:0] a,
                        input logic [7:0] n, input logic [127:0] d);
        check("req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = w; req_vec = v; req_addr = a; req_count = n; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Called at the negedge of a READ cycle; returns one negedge after the beat is consumed.
    task automatic beat(input logic [31:0] a, input logic vf, input logic [127:0] d,
                        input logic last, input logic err);
        check("rd_we", mem_we, 1'b0);
        check("rd_addr", mem_addr, err ? 128'd0 : {96'd0, a});
        check("rd_vf", mem_vf, vf);
        check("rd_ready", req_ready, 1'b0);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_rdata", rsp_rdata, d);
        check("rsp_last", rsp_last, last);
        check("rsp_err", rsp_err, err);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < MW; i++) mem[i] = '0;
        for (int i = 8; i < 32; i++) mem[i] = 32'h100 + 32'(i);
        for (int i = MW - 4; i < MW; i++) mem[i] = 32'h100 + 32'(i);
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1'b0);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 128'd0);
        check("rst_rdata", rsp_rdata, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);

        send(1'b1, 1'b1, 32'd0, 8'd5, VDATA);
        check("wr_we", mem_we, 1'b1);
        check("wr_addr", mem_addr, 128'd0);
        check("wr_vf", mem_vf, 1'b1);
        check("wr_wd", mem_wd, VDATA);
        @(negedge clk);
        check("wr_rsp_valid", rsp_valid, 1'b1);
        check("wr_rsp_rdata", rsp_rdata, 128'd0);
        check("wr_rsp_last", rsp_last, 1'b1);
        check("wr_rsp_we", mem_we, 1'b0);
        @(negedge clk);
        check("wr_we_cycles", 128'(we_cycles), 128'd1);
        check("wr_idle_valid", rsp_valid, 1'b0);
        send(1'b0, 1'b1, 32'd0, 8'd1, '0);
        beat(32'd0, 1'b1, VDATA, 1'b1, 1'b0);

        send(1'b1, 1'b0, 32'd10000, 8'd1, 128'd1);
        check("sst_vf", mem_vf, SCL_VF);
        repeat (2) @(negedge clk);
        send(1'b0, 1'b0, 32'd10000, 8'd1, '0);
        beat(32'd10000, SCL_VF, 128'd1, 1'b1, 1'b0);

        send(1'b0, 1'b1, 32'd8, 8'd3, '0);
        beat(32'd8, 1'b1, pat(8), 1'b0, 1'b0);
        beat(32'd12, 1'b1, pat(12), 1'b0, 1'b0);
        beat(32'd16, 1'b1, pat(16), 1'b1, 1'b0);

        send(1'b0, 1'b1, 32'd28, 8'd0, '0);
        beat(32'd28, 1'b1, pat(28), 1'b1, 1'b0);

        send(1'b0, 1'b1, 32'd20, 8'd2, '0);
        check("bp_rd_addr", mem_addr, 128'd20);
        rsp_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_rdata", rsp_rdata, pat(20));
            check("bp_addr", mem_addr, 128'd0);
            check("bp_last", rsp_last, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        beat(32'd24, 1'b1, pat(24), 1'b1, 1'b0);

        wb = we_cycles;
        send(1'b0, 1'b1, 32'(MW - 2), 8'd1, '0);
        beat(32'(MW - 2), 1'b1, 128'd0, 1'b1, 1'b1);
        send(1'b0, 1'b1, 32'(MW - 4), 8'd1, '0);
        beat(32'(MW - 4), 1'b1, pat(MW - 4), 1'b1, 1'b0);
        send(1'b1, 1'b1, 32'(MW - 3), 8'd1, VDATA);
        check("oob_st_we", mem_we, 1'b0);
        check("oob_st_addr", mem_addr, 128'd0);
        @(negedge clk);
        check("oob_st_err", rsp_err, 1'b1);
        check("oob_st_rdata", rsp_rdata, 128'd0);
        @(negedge clk);
        check("oob_we_cycles", 128'(we_cycles), 128'(wb));

        send(1'b1, 1'b1, 32'd40, 8'd1, VDATA);
        check("mid_we", mem_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_we", mem_we, 1'b0);
        check("arst_addr", mem_addr, 128'd0);
        check("arst_wd", mem_wd, 128'd0);
        check("arst_vf", mem_vf, 1'b0);
        check("arst_ready", req_ready, 1'b0);
        check("arst_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_mem", 128'(mem[40]), 128'd0);
        check("arst_after_ready", req_ready, 1'b1);
        check("arst_after_valid", rsp_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
